// File: rtl/test_status_monitor.sv
// End-of-test checker for riscv-tests runs. Snoops the register-file write
// port, shadows x3 (test number) and x27 (pass flag), and once x26 is written
// with 1 waits a settle window before latching a sticky pass/fail verdict.
// A free-running budget flags a timeout if no verdict is ever reached.
module test_status_monitor #(
  parameter int SETTLE_CYCLES  = 5,     // 1..255
  parameter int TIMEOUT_CYCLES = 2500,  // >= 1
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_we,
  input  logic [4:0]       wb_waddr,
  input  logic [31:0]      wb_wdata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [31:0]      fail_testnum,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  // IDLE only lasts the first cycle after reset release and otherwise
  // behaves exactly like RUN.
  typedef enum logic [1:0] {IDLE, RUN, SETTLE, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] x3_q, x27_q;
  logic [7:0]  settle_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  // x26 needs no shadow: every decision on it uses the incoming write.
  logic        active;
  logic        wr_x3, wr_x26, wr_x27;
  logic [31:0] x3_eff, x27_eff;
  logic        settle_expired, tmo_hit;
  logic        enter_done, verdict, verdict_pass, load_settle;

  // Write snooping and the effective (shadow or same-edge write) values.
  assign active  = (state != DONE);
  assign wr_x3   = wb_we && (wb_waddr == 5'd3);
  assign wr_x26  = wb_we && (wb_waddr == 5'd26);
  assign wr_x27  = wb_we && (wb_waddr == 5'd27);
  assign x3_eff  = wr_x3  ? wb_wdata : x3_q;
  assign x27_eff = wr_x27 ? wb_wdata : x27_q;
  assign settle_expired = (state == SETTLE) && (settle_cnt == 8'd0);
  assign tmo_hit = active && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and decision logic; a settle expiry outranks a same-edge timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_next   = state;
    enter_done   = 1'b0;
    verdict      = 1'b0;
    verdict_pass = 1'b0;
    load_settle  = 1'b0;
    unique case (state)
      IDLE, RUN: begin
        if (tmo_hit) begin
          state_next = DONE;
          enter_done = 1'b1;
        end else if (wr_x26 && (wb_wdata == 32'd1)) begin
          state_next  = SETTLE;
          load_settle = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      SETTLE: begin
        if (settle_expired) begin
          state_next   = DONE;
          enter_done   = 1'b1;
          verdict      = 1'b1;
          verdict_pass = (x27_eff == 32'd1);
        end else if (tmo_hit) begin
          state_next = DONE;
          enter_done = 1'b1;
        end else if (wr_x26 && (wb_wdata != 32'd1)) begin
          state_next = RUN;
        end
      end
      DONE: state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Shadows, counters and the sticky verdict outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      x3_q         <= '0;
      x27_q        <= '0;
      settle_cnt   <= '0;
      tmo_cnt      <= '0;
      cycle_count  <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= '0;
    end else if (active) begin
      x3_q    <= x3_eff;
      x27_q   <= x27_eff;
      tmo_cnt <= tmo_cnt + 1'b1;
      if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;

      if (load_settle)
        settle_cnt <= 8'(SETTLE_CYCLES - 1);
      else if ((state == SETTLE) && (settle_cnt != 8'd0))
        settle_cnt <= settle_cnt - 1'b1;

      if (enter_done) begin
        done         <= 1'b1;
        pass         <= verdict && verdict_pass;
        fail         <= verdict && !verdict_pass;
        timeout      <= !verdict;
        fail_testnum <= x3_eff;
      end
    end
  end

endmodule

// File: tb/tb_test_status_monitor.sv
// Directed bench for test_status_monitor: a table of pass/fail scenarios plus
// hand-written sequences for timeout, settle abort, reset-in-DONE and the
// settle/timeout tie. A second instance with a narrow cycle_count checks saturation.
module tb_test_status_monitor;

  localparam int SETTLE  = 5;
  localparam int TMO     = 60;
  localparam int TMO_SAT = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;

  logic        done, pass, fail, timeout;
  logic [31:0] fail_testnum, cycle_count;

  logic        s_done, s_pass, s_fail, s_timeout;
  logic [31:0] s_testnum;
  logic [3:0]  s_cc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  test_status_monitor #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_testnum(fail_testnum), .cycle_count(cycle_count)
  );

  test_status_monitor #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO_SAT), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .done(s_done), .pass(s_pass), .fail(s_fail), .timeout(s_timeout),
    .fail_testnum(s_testnum), .cycle_count(s_cc)
  );

  typedef struct {
    logic [31:0] x3;
    logic [31:0] x27;
    logic [4:0]  a27;       // address used for the "x27" write
    int          dly;       // -1: before the x26 write; 1..5: edges after it
    logic        exp_pass;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wb_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
    step();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; wb_we = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done"},    done,         0);
    check({tag, "_pass"},    pass,         0);
    check({tag, "_fail"},    fail,         0);
    check({tag, "_timeout"}, timeout,      0);
    check({tag, "_testnum"}, fail_testnum, 0);
    check({tag, "_cc"},      cycle_count,  0);
  endtask

  // x3 write, optional early x27 write, x26=1, then five settle edges.
  task automatic apply_vec(input vec_t v, input bit do_rst);
    if (do_rst) do_reset(2);
    idle(3);
    wr(5'd3, v.x3);
    if (v.dly < 0) wr(v.a27, v.x27);
    wr(5'd26, 32'd1);
    for (int c = 1; c <= SETTLE; c++) begin
      if (c == v.dly) begin wb_we = 1'b1; wb_waddr = v.a27; wb_wdata = v.x27; end
      step();
      if (c == SETTLE - 1) check("vec_pre_done", done, 0);
    end
    check("vec_done",    done,         1);
    check("vec_pass",    pass,         v.exp_pass);
    check("vec_fail",    fail,         !v.exp_pass);
    check("vec_timeout", timeout,      0);
    check("vec_testnum", fail_testnum, v.x3);
    check("vec_cc",      cycle_count,  (v.dly < 0) ? 11 : 10);
  endtask

  initial begin
    vecs[0] = '{x3: 32'd5,  x27: 32'd1, a27: 5'd27, dly: -1, exp_pass: 1'b1}; // T1
    vecs[1] = '{x3: 32'd7,  x27: 32'd0, a27: 5'd27, dly: -1, exp_pass: 1'b0}; // T2
    vecs[2] = '{x3: 32'd9,  x27: 32'd1, a27: 5'd27, dly: 3,  exp_pass: 1'b1}; // x27 inside settle
    vecs[3] = '{x3: 32'd9,  x27: 32'd1, a27: 5'd0,  dly: 3,  exp_pass: 1'b0}; // x0 write ignored
    vecs[4] = '{x3: 32'd11, x27: 32'd1, a27: 5'd27, dly: 5,  exp_pass: 1'b1}; // same-edge x27
    vecs[5] = '{x3: 32'd13, x27: 32'd2, a27: 5'd27, dly: -1, exp_pass: 1'b0}; // x27 != 1

    do_reset(2);
    check_zero("reset");

    foreach (vecs[i]) apply_vec(vecs[i], 1'b1);

    // Timeout: no x26 write; done exactly at TMO edges after release.
    do_reset(2);
    for (int n = 1; n <= TMO; n++) begin
      if (n == 1) begin wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h33; end
      step();
      if (n == TMO - 1) check("tmo_pre_done", done, 0);
    end
    check("tmo_done",    done,         1);
    check("tmo_timeout", timeout,      1);
    check("tmo_pass",    pass,         0);
    check("tmo_fail",    fail,         0);
    check("tmo_cc",      cycle_count,  TMO);
    check("tmo_testnum", fail_testnum, 32'h33);
    check("sat_timeout", s_timeout,    1);
    check("sat_cc",      s_cc,         4'hf);
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    idle(8);
    check("tmo_hold_timeout", timeout,      1);
    check("tmo_hold_pass",    pass,         0);
    check("tmo_hold_cc",      cycle_count,  TMO);
    check("tmo_hold_testnum", fail_testnum, 32'h33);

    // Settle abort by x26=0, then a fresh x26=1 gives a verdict.
    do_reset(2);
    idle(2);
    wr(5'd26, 32'd1);
    idle(1);
    wr(5'd26, 32'd0);
    idle(8);
    check("abort_no_done", done, 0);
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    idle(SETTLE - 1);
    check("abort_pre_done", done, 0);
    idle(1);
    check("abort_done", done, 1);
    check("abort_pass", pass, 1);

    // One-cycle reset while in DONE, then rerun T1 without another reset.
    do_reset(1);
    check_zero("rst_in_done");
    apply_vec(vecs[0], 1'b0);

    // Settle expiry on the timeout edge: verdict wins; same-edge x3 captured.
    do_reset(2);
    for (int n = 1; n <= TMO; n++) begin
      if (n == 1)       begin wb_we = 1'b1; wb_waddr = 5'd27; wb_wdata = 32'd1;  end
      if (n == 2)       begin wb_we = 1'b1; wb_waddr = 5'd3;  wb_wdata = 32'h44; end
      if (n == TMO - 5) begin wb_we = 1'b1; wb_waddr = 5'd26; wb_wdata = 32'd1;  end
      if (n == TMO)     begin wb_we = 1'b1; wb_waddr = 5'd3;  wb_wdata = 32'h45; end
      step();
      if (n == TMO - 1) check("tie_pre_done", done, 0);
    end
    check("tie_done",    done,         1);
    check("tie_pass",    pass,         1);
    check("tie_fail",    fail,         0);
    check("tie_timeout", timeout,      0);
    check("tie_cc",      cycle_count,  TMO);
    check("tie_testnum", fail_testnum, 32'h45);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
